// File: rtl/vit_pkg.sv
// vit_pkg: FSM encoding, state-count derivation and trellis predecessor rule for the Viterbi slice.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package vit_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRACE = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    TRACE = ST_TRACE,
    OUT   = ST_OUT
  } vit_state_e;

  // Number of trellis states for constraint length k.
  function automatic int vit_num_states(input int k);
    return 1 << (k - 1);
  endfunction

  // Width of a state index for constraint length k.
  function automatic int vit_state_width(input int k);
    return k - 1;
  endfunction

  // Predecessor of state s given its survivor decision d: {d, s[sw-1:1]}.
  // The ACS array uses the same rule to define what a decision bit means.
  function automatic logic [31:0] vit_pred(input logic [31:0] s, input logic d, input int sw);
    logic [31:0] dv;
    dv = {31'd0, d};
    return (dv << (sw - 1)) | (s >> 1);
  endfunction

endpackage

// File: rtl/vit_min_state.sv
// vit_min_state: argmin over NS unsigned path metrics, lowest index wins ties.
// Latency: purely combinational.
// Backpressure: none.
module vit_min_state
  import vit_pkg::*;
#(
  parameter int NS = 8,
  parameter int MW = 4,
  parameter int SW = 3
) (
  input  logic [NS*MW-1:0] pm_i,
  output logic [SW-1:0]    min_idx_o
);

  // Linear scan; strict less-than keeps the earliest index on equal metrics.
  always_comb begin
    logic [MW-1:0] best;
    best      = pm_i[0 +: MW];
    min_idx_o = '0;
    for (int s = 1; s < NS; s++) begin
      if (pm_i[s*MW +: MW] < best) begin
        best      = pm_i[s*MW +: MW];
        min_idx_o = SW'(s);
      end
    end
  end

endmodule

// File: rtl/viterbi_tb_unit.sv
// viterbi_tb_unit: survivor memory + traceback; one decoded bit per symbol once the window fills, full drain on dec_last.
// Latency: fill-1 TRACE cycles after the triggering accept (TB_DEPTH-1 in steady state), then OUT until taken.
// Backpressure: dec_ready only in IDLE; out_valid/out_bit/out_last held while out_ready=0. Option macro: VIT_ZERO_TAIL_EN.
module viterbi_tb_unit
  import vit_pkg::*;
#(
  parameter  int K        = 4,
  parameter  int TB_DEPTH = 15,
  parameter  int MW       = 4,
  localparam int NS       = vit_num_states(K),
  localparam int SW       = vit_state_width(K)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [NS-1:0]    dec,
  input  logic             dec_last,
  input  logic [NS*MW-1:0] pm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_last,
  output logic             busy
);

  localparam int PW = $clog2(TB_DEPTH);
  localparam int FW = $clog2(TB_DEPTH + 1);
  localparam logic [PW-1:0] LAST_COL = PW'(TB_DEPTH - 1);
  localparam logic [FW-1:0] FULL     = FW'(TB_DEPTH);

  vit_state_e    state_q, state_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [FW-1:0] cnt_q, cnt_d;
  logic          flush_q, flush_d;
  logic [SW-1:0] tb_q, tb_d;
  logic [SW-1:0] end_q, end_d;

  logic [NS-1:0] mem_q [TB_DEPTH];

  logic [SW-1:0] pm_min;
  logic          accept;
  logic [FW-1:0] fill_inc, fill_dec;
  logic [PW-1:0] wptr_inc, newest;

  vit_min_state #(
    .NS(NS),
    .MW(MW),
    .SW(SW)
  ) u_min (
    .pm_i      (pm),
    .min_idx_o (pm_min)
  );

  assign accept   = dec_valid & (state_q == IDLE);
  assign fill_inc = fill_q + 1'b1;
  assign fill_dec = fill_q - 1'b1;
  assign wptr_inc = (wptr_q == LAST_COL) ? '0 : wptr_q + 1'b1;
  // Column written by the most recent accept.
  assign newest   = (wptr_q == '0) ? LAST_COL : wptr_q - 1'b1;

  assign dec_ready = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign out_bit   = tb_q[0];
  assign out_last  = flush_q & (fill_q == FW'(1));
  assign busy      = (fill_q != '0) | (state_q != IDLE);

  // Survivor memory write; never cleared since a column is always written before it is traced.
  always_ff @(posedge clock) begin
    if (accept) begin
      mem_q[wptr_q] <= dec;
    end
  end

  // Next-state and datapath update for accept, traceback step and output handshake.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    tb_d    = tb_q;
    end_d   = end_q;
    unique case (state_q)
      IDLE: begin
        if (dec_valid) begin
          wptr_d = wptr_inc;
          fill_d = fill_inc;
`ifdef VIT_ZERO_TAIL_EN
          // Terminated trellis: the final column always ends in state 0.
          end_d = dec_last ? '0 : pm_min;
`else
          end_d = pm_min;
`endif
          if (dec_last) begin
            flush_d = 1'b1;
          end
          if ((fill_inc == FULL) || dec_last) begin
            tb_d    = end_d;
            rptr_d  = wptr_q;
            cnt_d   = fill_q;
            state_d = (fill_q == '0) ? OUT : TRACE;
          end
        end
      end
      TRACE: begin
        tb_d    = SW'(vit_pred(32'(tb_q), mem_q[rptr_q][tb_q], SW));
        rptr_d  = (rptr_q == '0) ? LAST_COL : rptr_q - 1'b1;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == FW'(1)) begin
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          fill_d = fill_dec;
          if (flush_q && (fill_dec != '0)) begin
            // Drain: retrace from the frame end for the next-oldest column.
            tb_d    = end_q;
            rptr_d  = newest;
            cnt_d   = fill_dec - 1'b1;
            state_d = (fill_dec == FW'(1)) ? OUT : TRACE;
          end else if (flush_q) begin
            flush_d = 1'b0;
            wptr_d  = '0;
            state_d = IDLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and pointer registers; reset discards any partial frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      tb_q    <= '0;
      end_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      tb_q    <= tb_d;
      end_q   <= end_d;
    end
  end

endmodule

// File: tb/tb_viterbi_tb_unit.sv
// tb_viterbi_tb_unit: randomized scoreboard bench for viterbi_tb_unit against a queue-based traceback model.
// Latency: checks first-output latency and steady-state accept spacing.
// Backpressure: exercises out_ready stalls and random out_ready; honours VIT_ZERO_TAIL_EN in the model.
module tb_viterbi_tb_unit;

  localparam int K        = 4;
  localparam int TB_DEPTH = 15;
  localparam int MW       = 4;
  localparam int NS       = 1 << (K - 1);

  logic             clock = 1'b0;
  logic             reset_n;
  logic             dec_valid;
  logic             dec_ready;
  logic [NS-1:0]    dec;
  logic             dec_last;
  logic [NS*MW-1:0] pm;
  logic             out_valid;
  logic             out_ready;
  logic             out_bit;
  logic             out_last;
  logic             busy;

  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   out_count = 0;
  logic rand_rdy  = 1'b0;
  logic rise_arm  = 1'b0;
  int   rise_cyc  = -1;
  logic prev_valid = 1'b0;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t          exp_q[$];
  logic [NS-1:0] win[$];

  viterbi_tb_unit #(
    .K(K),
    .TB_DEPTH(TB_DEPTH),
    .MW(MW)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .dec_valid (dec_valid),
    .dec_ready (dec_ready),
    .dec       (dec),
    .dec_last  (dec_last),
    .pm        (pm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: minimum metric, lowest index among equals.
  function automatic int best_state(input logic [NS*MW-1:0] p);
    int m[NS];
    int lo;
    lo = 1 << MW;
    for (int s = 0; s < NS; s++) begin
      m[s] = int'(p[s*MW +: MW]);
      if (m[s] < lo) lo = m[s];
    end
    for (int s = 0; s < NS; s++) begin
      if (m[s] == lo) return s;
    end
    return 0;
  endfunction

  // Walk back from the newest column to the second-oldest; the oldest column's bit is the LSB.
  function automatic logic trace_bit(input int start);
    int s;
    s = start;
    for (int i = win.size() - 1; i >= 1; i--) begin
      s = int'(win[i][s]) * (NS / 2) + s / 2;
    end
    return (s % 2) == 1;
  endfunction

  task automatic model_accept(input logic [NS-1:0] d, input logic [NS*MW-1:0] p, input logic last);
    int   es;
    exp_t e;
    win.push_back(d);
    es = best_state(p);
`ifdef VIT_ZERO_TAIL_EN
    if (last) es = 0;
`endif
    if (last) begin
      while (win.size() > 0) begin
        e.b    = trace_bit(es);
        e.last = (win.size() == 1);
        exp_q.push_back(e);
        void'(win.pop_front());
      end
    end else if (win.size() == TB_DEPTH) begin
      e.b    = trace_bit(es);
      e.last = 1'b0;
      exp_q.push_back(e);
      void'(win.pop_front());
    end
  endtask

  function automatic logic [NS*MW-1:0] pm_best(input int b);
    logic [NS*MW-1:0] p;
    p = '1;
    p[b*MW +: MW] = '0;
    return p;
  endfunction

  function automatic logic [NS*MW-1:0] pm_fill(input int v);
    logic [NS*MW-1:0] p;
    for (int s = 0; s < NS; s++) p[s*MW +: MW] = MW'(v);
    return p;
  endfunction

  function automatic logic [NS*MW-1:0] pm_rand();
    logic [NS*MW-1:0] p;
    for (int s = 0; s < NS; s++) p[s*MW +: MW] = MW'($urandom_range(0, (1 << MW) - 1));
    return p;
  endfunction

  // Monitor: pops the scoreboard on each output handshake and tracks out_valid rise time.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n) begin
      if (out_valid && !prev_valid && rise_arm) begin
        rise_cyc = cyc;
        rise_arm = 1'b0;
      end
      prev_valid = out_valid;
      if (out_valid && out_ready) begin
        out_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'(out_valid), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("out_bit", 32'(out_bit), 32'(e.b));
          chk("out_last", 32'(out_last), 32'(e.last));
        end
      end
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Random downstream readiness, changed just after the active edge.
  always @(posedge clock) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 9) < 7);
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge with the accept edge number.
  task automatic send(input logic [NS-1:0] d, input logic [NS*MW-1:0] p, input logic last, output int acc);
    int guard;
    guard     = 0;
    acc       = -1;
    dec_valid = 1'b1;
    dec       = d;
    pm        = p;
    dec_last  = last;
    while (!dec_ready && guard < 3000) begin
      @(negedge clock);
      guard++;
    end
    if (!dec_ready) begin
      chk("accept_timeout", 32'(dec_ready), 32'(1));
      dec_valid = 1'b0;
      dec_last  = 1'b0;
      return;
    end
    acc = cyc + 1;
    model_accept(d, p, last);
    @(posedge clock);
    @(negedge clock);
    dec_valid = 1'b0;
    dec_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (busy && guard < 5000) begin
      @(negedge clock);
      guard++;
    end
    chk("drain_busy", 32'(busy), 32'(0));
    chk("drain_pending", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic zero_frame(input string tag);
    int a, a15, n0;
    n0  = out_count;
    a15 = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 15) begin
        rise_arm = 1'b1;
        rise_cyc = -1;
      end
      send('0, pm_best(0), i == 20, a);
      if (i == 15) a15 = a;
    end
    wait_idle();
    chk($sformatf("%s_latency", tag), 32'(rise_cyc - a15), 32'(14));
    chk($sformatf("%s_count", tag), 32'(out_count - n0), 32'(20));
  endtask

  task automatic reset_checks(input string tag);
    chk($sformatf("%s_dec_ready", tag), 32'(dec_ready), 32'(1));
    chk($sformatf("%s_out_valid", tag), 32'(out_valid), 32'(0));
    chk($sformatf("%s_out_bit", tag), 32'(out_bit), 32'(0));
    chk($sformatf("%s_out_last", tag), 32'(out_last), 32'(0));
    chk($sformatf("%s_busy", tag), 32'(busy), 32'(0));
  endtask

  initial begin
    int   a, a15, a16, n0, n;
    logic b0;
    reset_n   = 1'b1;
    dec_valid = 1'b0;
    dec       = '0;
    dec_last  = 1'b0;
    pm        = '0;
    out_ready = 1'b1;
    #1 reset_n = 1'b0;
    #1 reset_checks("reset");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Steady zeros, 20 symbols.
    zero_frame("zeros");

    // All ones: traceback stays in state 7.
    n0 = out_count;
    a15 = 0;
    a16 = 0;
    for (int i = 1; i <= 16; i++) begin
      send(NS'(8'hFF), pm_best(7), i == 16, a);
      if (i == 15) a15 = a;
      if (i == 16) a16 = a;
    end
    wait_idle();
    chk("ones_spacing", 32'(a16 - a15), 32'(16));
    chk("ones_count", 32'(out_count - n0), 32'(16));

    // Backpressure on the first output of a random 17-symbol frame.
    n0 = out_count;
    out_ready = 1'b0;
    fork
      begin
        int a2;
        for (int i = 1; i <= 17; i++) send(NS'($urandom), pm_rand(), i == 17, a2);
      end
      begin
        int g;
        g = 0;
        while (!out_valid && g < 2000) begin
          @(negedge clock);
          g++;
        end
        chk("bp_valid_seen", 32'(out_valid), 32'(1));
        b0 = out_bit;
        repeat (5) begin
          @(negedge clock);
          chk("bp_hold_valid", 32'(out_valid), 32'(1));
          chk("bp_hold_bit", 32'(out_bit), 32'(b0));
          chk("bp_dec_ready", 32'(dec_ready), 32'(0));
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("bp_resume", 32'(out_valid), 32'(0));
      end
    join
    wait_idle();
    chk("bp_count", 32'(out_count - n0), 32'(17));

    // Short frame with tied metrics.
    n0 = out_count;
    send(NS'($urandom), pm_fill(8), 1'b0, a);
    send(NS'($urandom), pm_fill(8), 1'b0, a);
    repeat (4) @(negedge clock);
    chk("short_quiet", 32'(out_valid), 32'(0));
    chk("short_busy", 32'(busy), 32'(1));
    chk("short_none_yet", 32'(out_count - n0), 32'(0));
    send(NS'($urandom), pm_fill(8), 1'b1, a);
    wait_idle();
    chk("short_count", 32'(out_count - n0), 32'(3));

    // Short frame whose final metrics favour state 5.
    n0 = out_count;
    for (int i = 1; i <= 3; i++) begin
      logic [NS*MW-1:0] p;
      p = pm_fill(8);
      p[0*MW +: MW] = MW'(15);
      p[5*MW +: MW] = '0;
      send(NS'($urandom), p, i == 3, a);
    end
    wait_idle();
    chk("tail_count", 32'(out_count - n0), 32'(3));

    // Reset in the middle of a traceback, then a fresh zero frame.
    for (int i = 1; i <= 15; i++) send('0, pm_best(0), 1'b0, a);
    repeat (3) @(negedge clock);
    chk("midtrace_busy", 32'(busy), 32'(1));
    chk("midtrace_dec_ready", 32'(dec_ready), 32'(0));
    #2 reset_n = 1'b0;
    #1 reset_checks("midreset");
    win.delete();
    exp_q.delete();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    zero_frame("after_reset");

    // Randomized frames with random gaps and random downstream readiness.
    rand_rdy = 1'b1;
    for (int f = 0; f < 6; f++) begin
      n  = $urandom_range(1, 25);
      n0 = out_count;
      for (int i = 1; i <= n; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clock);
        send(NS'($urandom), pm_rand(), i == n, a);
      end
      wait_idle();
      chk("rand_count", 32'(out_count - n0), 32'(n));
    end
    rand_rdy = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/viterbi_tb_unit.md
# viterbi_tb_unit

Parametrised survivor-memory and traceback controller for the Viterbi decoder: generalises constraint length, traceback depth and path-metric width, and adds valid/ready handshakes and end-of-frame flush. It sits after the ACS array. Per trellis step it stores one decision bit per state, picks the best (minimum-metric) state, and traces back to emit one decoded bit per symbol once the window is full. On the frame's last symbol it drains every remaining bit.

## Interface
Parameters:
- K, 4, constraint length; NS = 2^(K-1) states, state index width SW = K-1.
- TB_DEPTH, 15, survivor window in columns; must be ≥2.
- MW, 4, unsigned path-metric width.

Ports:
- clock  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- dec_valid  in  1  decision column and metrics present.
- dec_ready  out  1  block accepts a column; equals (state==IDLE).
- dec  in  NS  decision bit per state; bit s = ACS survivor select of state s.
- dec_last  in  1  column is the frame's final symbol.
- pm  in  NS*MW  path metrics; state s at pm[s*MW +: MW].
- out_valid  out  1  decoded bit present.
- out_ready  in  1  downstream accepts the bit.
- out_bit  out  1  decoded bit, oldest first.
- out_last  out  1  final bit of the frame.
- busy  out  1  undecoded columns held or traceback active.

## Operation
- Storage: circular memory of TB_DEPTH columns × NS bits, plus the following registers.
  - wptr: next write column.
  - fill: undecoded columns, 0..TB_DEPTH.
  - rptr, tb_state, end_state, trace_cnt, and a flush flag.
- FSM states: IDLE, TRACE, OUT.
- IDLE, on a dec_valid&dec_ready edge:
  - Write dec into column wptr, then wptr++ (wraps TB_DEPTH-1→0) and fill++.
  - Capture end_state = argmin(pm); on a tie the lowest index wins.
  - If dec_last, set flush.
  - If the new fill==TB_DEPTH or dec_last, load tb_state=end_state, rptr=newest column, trace_cnt=fill-1, then go to TRACE, or to OUT when trace_cnt==0.
  - Otherwise stay in IDLE with no output.
- TRACE, each cycle:
  - tb_state ← {mem[rptr][tb_state], tb_state[SW-1:1]}.
  - rptr-- (wraps 0→TB_DEPTH-1) and trace_cnt--.
  - After the step that takes trace_cnt to 0, go to OUT.
- OUT:
  - out_bit = tb_state[0]; out_valid held until out_ready.
  - out_last = flush & (fill==1).
- On the OUT handshake, fill-- takes effect, then:
  - If flush and the new fill>0: reload tb_state=end_state, rptr=newest column, trace_cnt=fill-1, and go to TRACE (or OUT when trace_cnt==0).
  - If flush and the new fill==0: clear flush, set wptr=0, go to IDLE.
  - Otherwise go to IDLE.
- dec_valid outside IDLE is ignored; dec/pm are only sampled on the accept edge.
- A frame of N symbols yields exactly N out bits. A frame shorter than TB_DEPTH emits nothing until dec_last, then emits all N bits.
- Reset (any time, including mid-TRACE/OUT):
  - FSM→IDLE; wptr, fill, rptr, trace_cnt, flush, tb_state and end_state = 0.
  - The partial frame is discarded.
  - Memory contents are not cleared (never read before rewrite).

## Timing
- Reset values: dec_ready=1, out_valid=0, out_bit=0, out_last=0, busy=0.
- out_bit and out_last are registered-state derived and stable while out_valid=1.
- Latency: the accept edge that fills the window (or carries dec_last) is followed by out_valid high after fill-1 TRACE cycles; steady state is TB_DEPTH-1 cycles.
- Steady-state throughput with out_ready=1: one symbol per TB_DEPTH+1 cycles (1 IDLE + TB_DEPTH-1 TRACE + 1 OUT).
- Flush bit i (remaining fill f) costs f-1 TRACE cycles plus 1 OUT cycle.
- busy = (fill≠0) | (state≠IDLE).

## Configuration
- VIT_ZERO_TAIL_EN defined: the capture on a dec_last accept sets end_state=0 (terminated trellis), ignoring pm. Every flush traceback therefore starts from state 0.
- VIT_ZERO_TAIL_EN undefined: end_state is always argmin(pm) of the accepted column.
- Non-last columns use argmin in both builds.

## Structure
- Shared package vit_pkg holds:
  - the state-encoding localparams (IDLE, TRACE, OUT);
  - the NS/SW derivation function;
  - the predecessor rule {decision, s[SW-1:1]}, shared with the ACS array.
- One sub-module, vit_min_state: parametrised combinational argmin over NS metrics of MW bits, lowest index on ties.

## Test plan
- Reset: drive reset_n=0 mid-run → dec_ready=1, out_valid=0, out_last=0, busy=0 immediately.
- Steady zeros, K=4/TB_DEPTH=15: dec=0x00, pm0=0, others 15, 20 symbols, dec_last on the 20th, out_ready=1.
  - First out_valid 14 cycles after the 15th accept.
  - 20 bits, all 0; out_last only on the 20th.
- All ones: dec=0xFF, pm7=0, others 15, 16 symbols.
  - Traceback stays in state 7, so every out_bit=1.
  - Accept spacing is 16 cycles.
- Backpressure: hold out_ready=0 for 5 cycles in OUT.
  - out_valid and out_bit stable, dec_ready=0, no column accepted.
  - Resumes on the out_ready edge.
- Short frame and ties: 3 symbols with all pm=8, dec_last on the 3rd.
  - No output before the 3rd accept, then exactly 3 bits with end_state=0 and out_last on the 3rd.
  - With VIT_ZERO_TAIL_EN and pm0=15/pm5=0, flush still starts from state 0.
- Reset mid-TRACE: assert reset_n low, then run a fresh 20-symbol zero frame.
  - Output identical to scenario 2.
